// File: rtl/led_matrix_scan.sv
// Multiplexed LED matrix scanner: one pixel slot at a time, per-slot PWM,
// anti-ghost blanking, image/brightness snapshot taken at each frame start.
// Ports: clk, resetn (async low), enable, brightness, ledbits in;
//        aled (anodes, active-low), kled_tri (cathode OEs), frame_start out.
module led_matrix_scan #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int PRESCALE    = 32,
  parameter int BLANK_TICKS = 1,
  parameter int PWM_BITS    = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [PWM_BITS-1:0]    brightness,
  input  logic [ROWS*COLS-1:0]   ledbits,
  output logic [COLS-1:0]        aled,
  output logic [ROWS-1:0]        kled_tri,
  output logic                   frame_start
);

  localparam int N  = ROWS * COLS;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = PWM_BITS + $clog2(BLANK_TICKS + 2);

  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLK_LAST  =
    CW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
  localparam logic [CW-1:0] PWM_LAST  = CW'((1 << PWM_BITS) - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    PWM   = 2'd2
  } state_t;

  localparam state_t SLOT_ENTRY = (BLANK_TICKS > 0) ? BLANK : PWM;

  state_t               state, state_n;
  logic [PW-1:0]        pre, pre_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [SW-1:0]        slot, slot_n;
  logic [N-1:0]         img, img_n;
  logic [PWM_BITS-1:0]  br, br_n;
  logic                 fs_n;
  logic [COLS-1:0]      aled_n;
  logic [ROWS-1:0]      kled_n;
  logic                 tick;
  logic                 start;
  logic                 lit;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      pre   <= '0;
      cnt   <= '0;
      slot  <= '0;
      img   <= '0;
      br    <= '0;
    end else begin
      state <= state_n;
      pre   <= pre_n;
      cnt   <= cnt_n;
      slot  <= slot_n;
      img   <= img_n;
      br    <= br_n;
    end
  end

  always_comb begin
    state_n = state;
    pre_n   = pre;
    cnt_n   = cnt;
    slot_n  = slot;
    img_n   = img;
    br_n    = br;
    fs_n    = 1'b0;
    start   = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      pre_n   = '0;
      cnt_n   = '0;
      slot_n  = '0;
    end else if (state == IDLE) begin
      start = 1'b1;
    end else begin
      pre_n = tick ? '0 : pre + 1'b1;
      if (tick) begin
        unique case (state)
          BLANK: begin
            if (cnt == BLK_LAST) begin
              state_n = PWM;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          PWM: begin
            if (cnt == PWM_LAST) begin
              cnt_n   = '0;
              state_n = SLOT_ENTRY;
              if (slot == SLOT_LAST) start = 1'b1;
              else slot_n = slot + 1'b1;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
    // Frame boundary: from IDLE or on slot wrap, no gap between frames.
    if (start) begin
      state_n = SLOT_ENTRY;
      img_n   = ledbits;
      br_n    = brightness;
      slot_n  = '0;
      pre_n   = '0;
      cnt_n   = '0;
      fs_n    = 1'b1;
    end
  end

  // Outputs decoded from next-state values so they switch on the
  // same edge as the phase/tick counter.
  always_comb begin
    aled_n = '1;
    kled_n = '0;
    lit    = (state_n == PWM) &&
             (cnt_n < {{(CW-PWM_BITS){1'b0}}, br_n});
    for (int c = 0; c < COLS; c++) begin
      if (lit && (int'(slot_n) % COLS) == c) aled_n[c] = 1'b0;
    end
    for (int r = 0; r < ROWS; r++) begin
      if (lit && img_n[slot_n] && (int'(slot_n) / COLS) == r)
        kled_n[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aled        <= '1;
      kled_tri    <= '0;
      frame_start <= 1'b0;
    end else begin
      aled        <= aled_n;
      kled_tri    <= kled_n;
      frame_start <= fs_n;
    end
  end

endmodule

// File: doc/led_matrix_scan.md
Name: led_matrix_scan

Overview:
Parametrised multiplexed LED matrix driver. It scans a ROWS x COLS matrix one pixel slot at a time. Each slot has per-slot PWM brightness and an anti-ghosting blanking interval. The pixel image and brightness are double-buffered so they only change at frame boundaries. It sits between status/register logic and the board pins: anodes are active-low, and cathodes are tri-state output enables (pins tied high, driven through kled_tri).

Parameters:
ROWS, 4, number of cathode lines (kled_tri width)
COLS, 4, number of anode lines (aled width)
PRESCALE, 32, clk cycles per scan tick (>=1)
BLANK_TICKS, 1, all-off ticks at the start of each slot (>=0; 0 = no blank phase)
PWM_BITS, 3, brightness width; PWM window per slot = 2^PWM_BITS ticks

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
enable  in  1  run scanning; low = display off, scanner idle
brightness  in  PWM_BITS  global on-ticks per slot, sampled at frame start
ledbits  in  ROWS*COLS  pixel image; bit i -> row i/COLS, column i%COLS; sampled at frame start
aled  out  COLS  anode drive, active-low, one-hot-low when lit
kled_tri  out  ROWS  cathode output enables, one-hot when lit
frame_start  out  1  one-cycle pulse on the first cycle of every frame

Behaviour:
- Reset (async, resetn=0): aled=all 1s, kled_tri=0, frame_start=0, state IDLE, prescaler/tick/slot counters=0, shadow image=0, shadow brightness=0.
- All outputs are registered; no combinational path from input to output.
- Prescaler: counts 0..PRESCALE-1 while not IDLE. tick = (pre==PRESCALE-1). Phase counters advance only on tick.
- States: IDLE, BLANK, PWM.
- IDLE -> BLANK on the clk edge where enable=1. BLANK_TICKS=0 means go straight to PWM.
  - That edge captures ledbits->shadow and brightness->shadow, sets slot=0, pre=0, and drives frame_start=1 for the following cycle.
- BLANK: lasts BLANK_TICKS ticks; aled=all 1s, kled_tri=0; then -> PWM.
- PWM: tick counter t runs 0..2^PWM_BITS-1.
  - While t < shadow brightness: aled = all 1s except bit (slot%COLS)=0; kled_tri = shadow[slot] ? one-hot bit (slot/COLS) : 0.
  - Otherwise aled=all 1s, kled_tri=0.
  - After the last t: slot++, -> BLANK (or PWM if BLANK_TICKS=0).
- Slot wrap: the tick ending slot ROWS*COLS-1 wraps slot to 0. On the same edge it re-captures ledbits/brightness and pulses frame_start in the next cycle. There is no idle gap between frames.
- Output timing: output values change on the same edge that the phase or t changes, so each lit pixel is on for exactly brightness*PRESCALE cycles per frame.
- Frame period = ROWS*COLS*(BLANK_TICKS+2^PWM_BITS)*PRESCALE cycles (defaults: 4608).
- brightness=0: no pixel ever lit; aled stays all 1s. Maximum duty is (2^PWM_BITS-1)/2^PWM_BITS.
- ledbits/brightness changes mid-frame have no visible effect until the next frame_start.
- enable=0 in any state: on the next edge -> IDLE, aled=all 1s, kled_tri=0, counters cleared, frame_start=0. An enable pulse that ends on the same edge as a wrap still goes IDLE, and no frame_start is produced.
- Reset mid-slot: outputs go off immediately (async), independent of clk.
- Never more than one aled bit low and never more than one kled_tri bit high in any cycle.

Test Plan:
1. Defaults, enable=1, ledbits=16'h0020, brightness=7 -> frame_start every 4608 cycles. In slot 5 after 32 blank cycles: aled=4'b1101, kled_tri=4'b0010 for exactly 224 cycles, then off for 32 cycles. kled_tri=0 in all other slots.
2. brightness=0, ledbits=16'hFFFF -> aled=4'b1111 and kled_tri=0 for a full frame. frame_start still pulses.
3. Change ledbits 16'h0001->16'h8000 at cycle 1000 of a frame -> slot 0 still lit this frame. From the next frame_start only slot 15 is lit (aled=4'b0111, kled_tri=4'b1000).
4. Drop enable during slot 3 PWM -> one cycle later aled=4'b1111, kled_tri=0, no frame_start. Re-raise enable -> frame_start one cycle later; slot 0 restarts with a fresh snapshot.
5. Assert resetn=0 mid-lit window -> outputs off in the same cycle, before any clk edge. Release with enable=1 -> normal frame start.
6. ROWS=2, COLS=8, PRESCALE=4, BLANK_TICKS=0, PWM_BITS=2, ledbits bit 9, brightness=3 -> frame period 256 cycles. Slot 9: aled=8'b11111101, kled_tri=2'b10 for 12 cycles, then off for 4 cycles.
